wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter: N requesters compete for one downstream port, and the winner holds the grant for up to weight+1 accepted beats before rotation moves on. It succeeds the fixed 4-input round-robin arbiter in the TLP path. It adds a generic channel count, per-requester weights, and a valid/ready handshake toward the consumer (TLP mux / link-layer queue).

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 34 +++
 rtl/wrr_arbiter.sv | 96 +++++++++
 tb/tb_wrr_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: state encoding
// and the index-width helper.
package arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;
    logic [IDW:0]   wrapped;

    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        // ptr and off are both < N, so a single subtraction restores the range
        if (sum >= (IDW + 1)'(N)) wrapped = sum - (IDW + 1)'(N);
        else                      wrapped = sum;
        any = |req;
        idx = wrapped[IDW-1:0];
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a holder keeps the grant for up to weight+1
// accepted beats, then priority rotates past it.
//
// state   | meaning
// S_IDLE  | no grant outstanding, waiting for any request
// S_GRANT | out_id holds the grant, cnt = remaining beats - 1
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N),
    parameter int WW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            ready,
    output logic            valid,
    output logic [IDW-1:0]  out_id,
    output logic [N-1:0]    gnt
);

    arb_state_e     state, state_nxt;
    logic [IDW-1:0] id_nxt;
    logic [WW-1:0]  cnt, cnt_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic [IDW:0]   pick_inc;
    logic [IDW-1:0] ptr_after;
    logic           load;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        pick_inc = {1'b0, pick_idx} + (IDW + 1)'(1);
        if (pick_inc == (IDW + 1)'(N)) ptr_after = '0;
        else                           ptr_after = pick_inc[IDW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            out_id <= '0;
            cnt    <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_nxt;
            out_id <= id_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
        end
    end

    // ptr already points past the holder, so the holder is searched last
    always_comb begin
        state_nxt = state;
        id_nxt    = out_id;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_any) load = 1'b1;
            end
            S_GRANT: begin
                if (ready) begin
                    if (cnt != '0 && req[out_id]) cnt_nxt = cnt - WW'(1);
                    else if (pick_any)            load    = 1'b1;
                    else                          state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (load) begin
            state_nxt = S_GRANT;
            id_nxt    = pick_idx;
            cnt_nxt   = weight[pick_idx*WW +: WW];
            ptr_nxt   = ptr_after;
        end
    end

    assign valid = (state == S_GRANT);

    always_comb begin
        gnt = '0;
        if (valid) gnt[out_id] = 1'b1;
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter (N=4, WW=2) with hand-computed expectations.
module tb_wrr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] weight;
    logic       ready;
    logic       valid;
    logic [1:0] out_id;
    logic [3:0] gnt;

    int n_checks = 0;
    int n_fail   = 0;

    int rot_exp[5]  = '{3, 0, 1, 2, 3};
    int wgt_exp[11] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
    int cnt_exp[5]  = '{1, 0, 1, 0, 1};

    wrr_arbiter #(.N(4), .IDW(2), .WW(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .weight (weight),
        .ready  (ready),
        .valid  (valid),
        .out_id (out_id),
        .gnt    (gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        weight = 8'h00;
        ready  = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);

        reset = 1'b0;
        tick();
        check("idle_no_req", 32'(valid), 32'd0);

        req = 4'b0100;
        tick();
        check("first_valid", 32'(valid), 32'd1);
        check("first_id", 32'(out_id), 32'd2);
        check("first_gnt", 32'(gnt), 32'b0100);
        check("first_ptr", 32'(dut.ptr), 32'd3);

        // weights all zero: one beat each
        ready = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rot_id%0d", i), 32'(out_id), 32'(rot_exp[i]));
            check($sformatf("rot_valid%0d", i), 32'(valid), 32'd1);
        end

        // weights {3,2,1,0}; holder 3 was loaded with 0 so it leaves after one beat
        weight = 8'b11_10_01_00;
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("wgt_id%0d", i), 32'(out_id), 32'(wgt_exp[i]));
            check($sformatf("wgt_gnt%0d", i), 32'(gnt), 32'(1 << wgt_exp[i]));
        end

        // holder 1 with weight 2, stalled while its request drops
        weight = 8'b00_00_10_00;
        tick();
        check("stall_load_id", 32'(out_id), 32'd1);
        check("stall_load_cnt", 32'(dut.cnt), 32'd2);
        tick();
        check("stall_dec_cnt", 32'(dut.cnt), 32'd1);
        ready = 1'b0;
        req   = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_id%0d", i), 32'(out_id), 32'd1);
            check($sformatf("stall_valid%0d", i), 32'(valid), 32'd1);
        end
        ready = 1'b1;
        tick();
        check("stall_release_id", 32'(out_id), 32'd2);
        check("stall_release_valid", 32'(valid), 32'd1);

        // sole requester 0 with weight 1: reload every two beats
        req    = 4'b0001;
        weight = 8'b00_00_00_01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sole_id%0d", i), 32'(out_id), 32'd0);
            check($sformatf("sole_valid%0d", i), 32'(valid), 32'd1);
            check($sformatf("sole_cnt%0d", i), 32'(dut.cnt), 32'(cnt_exp[i]));
        end

        req = 4'b0000;
        tick();
        check("to_idle_valid", 32'(valid), 32'd0);
        check("to_idle_gnt", 32'(gnt), 32'd0);

        // grant id 3 (searched from ptr=1), then reset between edges
        req   = 4'b1000;
        ready = 1'b0;
        tick();
        check("pre_rst_id", 32'(out_id), 32'd3);
        check("pre_rst_valid", 32'(valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(valid), 32'd0);
        check("async_out_id", 32'(out_id), 32'd0);
        check("async_gnt", 32'(gnt), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        check("post_rst_id", 32'(out_id), 32'd3);
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_ptr", 32'(dut.ptr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
